// File: rtl/bls_ctrl_pkg.sv
// Shared types and helpers for the multi-word borrow-lookahead subtract sequencer.
package bls_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nibble counter width: clog2(nib), never narrower than one bit.
    function automatic int cnt_width(input int nib);
        int w;
        w = $clog2(nib);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bls_multiword_sub_ctrl_shreg.sv
// bls_nib_shreg: right-shift-by-one-nibble register with parallel load and synchronous active-low reset.
module bls_nib_shreg
    import bls_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [W-1:0]        load_val,
    input  logic                shift,
    input  logic [NIBBLE_W-1:0] shift_in,
    output logic [W-1:0]        q
);

    logic [W+NIBBLE_W-1:0] cat;

    assign cat = {shift_in, q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= cat[W+NIBBLE_W-1:NIBBLE_W];
        end
    end

endmodule

// File: rtl/bls_multiword_sub_ctrl.sv
// Sequences a WIDTH-bit A - B - Bin through one external 4-bit borrow-lookahead subtractor, LSB nibble first.
// Optional: define BLS_SUB_SIGNED_OVF_EN to produce the signed overflow flag on ovf.
//
// state | meaning
// IDLE  | ready for operands (in_ready=1)
// RUN   | one nibble per clock through the external BLS
// DONE  | result held, out_valid=1 until out_ready
module bls_multiword_sub_ctrl
    import bls_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int NIB = WIDTH / NIBBLE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic [3:0]       bls_x,
    output logic [3:0]       bls_y,
    output logic             bls_bin,
    input  logic [3:0]       bls_diff,
    input  logic             bls_bout
);

    localparam int CNT_W = cnt_width(NIB);

    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic               brw;
    logic               accept;
    logic               run_step;
    logic               last;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH+3:0]   res_cat;
    logic [WIDTH-1:0]   res_next;

    assign last     = (cnt == CNT_W'(NIB - 1));
    assign res_cat  = {bls_diff, res_q};
    assign res_next = res_cat[WIDTH+3:4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        bls_x     = 4'h0;
        bls_y     = 4'h0;
        bls_bin   = 1'b0;
        accept    = 1'b0;
        run_step  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                bls_x    = a_q[3:0];
                bls_y    = b_q[3:0];
                bls_bin  = brw;
                run_step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            brw  <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= '0;
                brw <= bin;
            end
            if (run_step) begin
                cnt <= cnt + CNT_W'(1);
                brw <= bls_bout;
                if (last) begin
                    diff <= res_next;
                    bout <= bls_bout;
                end
            end
        end
    end

    bls_nib_shreg #(.W(WIDTH)) u_a_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (a),
        .shift    (run_step),
        .shift_in (4'h0),
        .q        (a_q)
    );

    bls_nib_shreg #(.W(WIDTH)) u_b_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (b),
        .shift    (run_step),
        .shift_in (4'h0),
        .q        (b_q)
    );

    // Result enters at the top so the LSB nibble lands at [3:0] after NIB shifts.
    bls_nib_shreg #(.W(WIDTH)) u_res_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val ('0),
        .shift    (run_step),
        .shift_in (bls_diff),
        .q        (res_q)
    );

`ifdef BLS_SUB_SIGNED_OVF_EN
    logic a_sgn;
    logic b_sgn;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sgn <= 1'b0;
            b_sgn <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (accept) begin
                a_sgn <= a[WIDTH-1];
                b_sgn <= b[WIDTH-1];
            end
            if (run_step && last) begin
                ovf <= (a_sgn != b_sgn) && (bls_diff[3] != a_sgn);
            end else if (state == DONE && out_ready) begin
                ovf <= 1'b0;
            end
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bls_multiword_sub_ctrl.sv
// Directed bench for bls_multiword_sub_ctrl (WIDTH=16) with a behavioural 4-bit BLS attached.
module tb_bls_multiword_sub_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        busy;
    logic [3:0]  bls_x;
    logic [3:0]  bls_y;
    logic        bls_bin;
    logic [3:0]  bls_diff;
    logic        bls_bout;

    int tests  = 0;
    int failed = 0;
    int acc_cnt = 0;

    always #5 clk = ~clk;

    // External 4-bit subtractor: {bout,diff} = x - y - bin in 5-bit two's complement.
    logic [4:0] bls_t;
    assign bls_t    = {1'b0, bls_x} - {1'b0, bls_y} - {4'b0, bls_bin};
    assign bls_diff = bls_t[3:0];
    assign bls_bout = bls_t[4];

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) acc_cnt++;
    end

    bls_multiword_sub_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .busy      (busy),
        .bls_x     (bls_x),
        .bls_y     (bls_y),
        .bls_bin   (bls_bin),
        .bls_diff  (bls_diff),
        .bls_bout  (bls_bout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands for one edge; returns at the negedge after the accept edge.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic bi);
        @(negedge clk);
        chk("pre_in_ready", {31'b0, in_ready}, 32'd1);
        a = av; b = bv; bin = bi; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    endtask

    // Counts edges from (and including) the accept edge until out_valid is seen.
    task automatic wait_done(input string tag, output int lat);
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            tests++;
            failed++;
            $error("FAIL %s_timeout: observed out_valid 0 expected 1", tag);
        end
    endtask

    task automatic finish_op;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_out_valid", {31'b0, out_valid}, 32'd0);
        chk("post_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic bi, input logic [15:0] ed, input logic eb, input logic eo);
        int lat;
        start_op(av, bv, bi);
        wait_done(tag, lat);
        chk({tag, "_lat"}, lat, 32'd5);
        chk({tag, "_diff"}, {16'b0, diff}, {16'b0, ed});
        chk({tag, "_bout"}, {31'b0, bout}, {31'b0, eb});
        chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
        finish_op();
    endtask

    logic        ovf_exp;
    logic [15:0] held_diff;
    logic        held_bout;
    int          lat;
    int          acc0;

    initial begin
`ifdef BLS_SUB_SIGNED_OVF_EN
        ovf_exp = 1'b1;
`else
        ovf_exp = 1'b0;
`endif
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0; b = 16'h0; bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_diff", {16'b0, diff}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_bls_x", {28'b0, bls_x}, 32'd0);
        rst_n = 1'b1;

        run_op("t1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);

        // 0 - 1: borrow ripples into every later nibble
        start_op(16'h0000, 16'h0001, 1'b0);
        chk("t2_c1_bin", {31'b0, bls_bin}, 32'd0);
        chk("t2_c1_y", {28'b0, bls_y}, 32'd1);
        chk("t2_c1_busy", {31'b0, busy}, 32'd1);
        chk("t2_c1_in_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            chk("t2_run_bin", {31'b0, bls_bin}, 32'd1);
        end
        @(negedge clk);
        chk("t2_out_valid", {31'b0, out_valid}, 32'd1);
        chk("t2_diff", {16'b0, diff}, 32'h0000_FFFF);
        chk("t2_bout", {31'b0, bout}, 32'd1);
        chk("t2_done_bls_bin", {31'b0, bls_bin}, 32'd0);
        finish_op();

        run_op("t3a", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("t3b", 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0);

        // Backpressure with in_valid held high throughout the operation
        acc0 = acc_cnt;
        @(negedge clk);
        a = 16'h1111; b = 16'h0101; bin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555;
        wait_done("bp", lat);
        chk("bp_lat", lat, 32'd5);
        chk("bp_diff", {16'b0, diff}, 32'h0000_1010);
        held_diff = diff;
        held_bout = bout;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_hold_diff", {16'b0, diff}, {16'b0, held_diff});
            chk("bp_hold_bout", {31'b0, bout}, {31'b0, held_bout});
            chk("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        finish_op();
        chk("bp_accepts", acc_cnt - acc0, 32'd1);

        // Reset in RUN cycle 2 discards the operation
        start_op(16'h1234, 16'h0001, 1'b0);
        @(negedge clk);
        chk("rr_busy_before", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rr_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rr_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rr_diff", {16'b0, diff}, 32'd0);
        chk("rr_busy", {31'b0, busy}, 32'd0);
        run_op("rr_next", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0);

        run_op("ovf1", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, ovf_exp);
        chk("ovf1_cleared", {31'b0, ovf}, 32'd0);
        run_op("ovf0", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFE, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bls_multiword_sub_ctrl.md
Name: bls_multiword_sub_ctrl

Overview:
Sequencer that runs a WIDTH-bit subtraction D = A - B - Bin nibble by nibble on one shared 4-bit borrow-lookahead subtractor (BLS) datapath instance.
- Latches operands on a valid/ready handshake.
- Drives one nibble per clock into the external BLS, LSB nibble first.
- Registers the borrow between nibbles and assembles the result.
- Presents the result on a valid/ready output handshake.
- Sits between the lab top level (switch/button input) and the combinational BLS.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibble steps; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  controller can accept operands
- a  input  WIDTH  minuend X
- b  input  WIDTH  subtrahend Y
- bin  input  1  initial borrow-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  registered difference
- bout  output  1  registered final borrow-out
- ovf  output  1  signed overflow flag (see Optional Feature)
- busy  output  1  high in RUN or DONE
- bls_x  output  4  nibble to BLS X
- bls_y  output  4  nibble to BLS Y
- bls_bin  output  1  borrow to BLS Bin
- bls_diff  input  4  BLS Diff
- bls_bout  input  1  BLS Bout

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State IDLE; all registers cleared.
  - in_ready=1; out_valid=0; diff=0; bout=0; ovf=0; busy=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready:
    - latch a, b and bin into shift registers A_sr, B_sr and the borrow register brw;
    - clear nibble counter cnt and the result shift register;
    - go to RUN.
- RUN:
  - in_ready=0.
  - Combinational drive: bls_x=A_sr[3:0], bls_y=B_sr[3:0], bls_bin=brw.
  - Each clock:
    - brw <= bls_bout;
    - result shift register shifts right by 4, with bls_diff entering at [WIDTH-1:WIDTH-4];
    - A_sr and B_sr shift right by 4;
    - cnt increments.
  - When cnt==NIB-1: go to DONE, diff <= final assembled value, bout <= bls_bout.
- DONE:
  - out_valid=1; diff and bout are held stable.
  - On out_ready: go to IDLE, and out_valid falls next cycle.
  - A new in_valid is accepted no earlier than the cycle after IDLE is re-entered; no same-cycle turnaround.
- Outside RUN: bls_x=0, bls_y=0, bls_bin=0.
- Latency: accept edge at cycle t, out_valid high from cycle t+NIB+1. For WIDTH=16 that is 5 cycles.
- Throughput: one operation per NIB+2 cycles with out_ready held high.
- Timing: the clock period must exceed the worst-case BLS combinational delay (40 time units in the gate-level model). The controller samples bls_diff/bls_bout exactly one edge after driving.
- Operand inputs and bin are ignored after the accept edge. in_valid while busy has no effect.
- out_ready while not in DONE is ignored.
- Reset mid-RUN or in DONE: aborts, the partial result is discarded, and all outputs take their reset values.
- NIB=1: RUN lasts one cycle.

Optional Feature:
- Macro BLS_SUB_SIGNED_OVF_EN.
- Defined: in the last RUN cycle, ovf <= (a[WIDTH-1] != b[WIDTH-1]) && (bls_diff[3] != a[WIDTH-1]), using the latched sign bits. ovf is held in DONE and cleared on leaving DONE.
- Undefined: ovf is constant 0 and no sign registers exist.

Decomposition:
- Shared package bls_ctrl_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - NIBBLE_W=4;
  - a function computing the counter width, clog2(NIB), minimum 1.
- One natural sub-module: bls_nib_shreg, a parameterised right-shift-by-4 register with parallel load. It is instantiated three times: for A, for B, and for the result.
- The BLS itself stays external and is connected at the parent.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0; out_valid exactly 5 cycles after accept.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1; bls_bin in RUN cycles 2-4 equals 1.
- a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1. Then a second request with a=0xFFFF, b=0x0000, bin=0 -> diff=0xFFFF, bout=0.
- Backpressure: out_ready low for 3 cycles in DONE -> diff/bout stable and in_ready=0. out_ready high -> IDLE, with in_ready=1 the next cycle. in_valid held high during busy -> only one accept.
- Reset mid-operation: rst_n=0 in RUN cycle 2 -> next cycle state IDLE, diff=0, out_valid=0; a following 0x00FF-0x000F returns 0x00F0.
- With BLS_SUB_SIGNED_OVF_EN: 0x8000-0x0001 -> diff=0x7FFF, ovf=1; 0x7FFF-0x0001 -> ovf=0. Without the macro: ovf=0 for both.
